pipe_hazard_ctrl: RTL and testbench

// - Sequences the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB buffers + PC): generates per-stage enable/flush.
// - Handles post-reset pipeline drain, load-use stalls, EX-resolved redirects (Branch/Jal/Jalr) and multi-cycle data-memory waits.
// - Sits beside the datapath; consumes decoded ID fields, ID/EX control bits and the data-memory handshake.

---
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: enable/flush sequencer for the 5-stage pipeline covering boot drain, load-use,
// EX redirects and data-memory waits. Define HAZ_PERF_CNT_EN to add the stall/flush/memwait counters.
module pipe_hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 255
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt,
`endif
    output logic             mem_err
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [BOOT_W-1:0] BOOT_LAST  = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    state_t             state_reg, state_next;
    logic [BOOT_W-1:0]  boot_cnt_reg, boot_cnt_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic               mem_err_reg, mem_err_next;

    logic               active;
    logic               mem_stall;
    logic               load_use;

    assign active = (state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT);

    // Once waiting, only the ack releases the freeze; the frozen EX/MEM still holds mem_req.
    assign mem_stall = ~mem_ack & ((state_reg == ST_MEM_WAIT) | mem_req);

    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

    assign mem_err = mem_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_BOOT;
            boot_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            boot_cnt_reg <= boot_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        boot_cnt_next = boot_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = mem_err_reg;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        memwb_flush   = 1'b0;

        case (state_reg)
            ST_BOOT: begin
                pc_en       = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_flush = 1'b1;
                if (boot_cnt_reg == BOOT_LAST) begin
                    state_next    = ST_RUN;
                    boot_cnt_next = '0;
                end else begin
                    boot_cnt_next = boot_cnt_reg + 1'b1;
                end
            end

            ST_RUN, ST_MEM_WAIT: begin
                if (mem_stall) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_flush = 1'b1;
                    state_next  = ST_MEM_WAIT;
                    if (state_reg == ST_RUN) begin
                        wait_cnt_next = WAIT_W'(1);
                    end else begin
                        if (wait_cnt_reg != '1)
                            wait_cnt_next = wait_cnt_reg + 1'b1;
                        // A timeout only counts while the access is still outstanding.
                        if (TIMEOUT_EN && (wait_cnt_reg == WAIT_LIMIT))
                            mem_err_next = 1'b1;
                    end
                end else begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                    if (ex_redirect) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg, memwait_cnt_reg;
    logic             lu_evt, redir_evt, wait_evt;

    // Events are counted only when the rule actually drives the outputs.
    assign lu_evt    = active && !mem_stall && !ex_redirect && load_use;
    assign redir_evt = active && !mem_stall && ex_redirect;
    assign wait_evt  = (state_reg == ST_MEM_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg   <= '0;
            flush_cnt_reg   <= '0;
            memwait_cnt_reg <= '0;
        end else begin
            if (lu_evt && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (redir_evt && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            if (wait_evt && (memwait_cnt_reg != '1))
                memwait_cnt_reg <= memwait_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt   = stall_cnt_reg;
    assign flush_cnt   = flush_cnt_reg;
    assign memwait_cnt = memwait_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int BOOT = 2;
    localparam int TO   = 4;

    // Output vector order: {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
    localparam logic [8:0] V_BOOT  = 9'b0_1111_1111;
    localparam logic [8:0] V_RUN   = 9'b1_1111_0000;
    localparam logic [8:0] V_FRZ   = 9'b0_0001_0001;
    localparam logic [8:0] V_REDIR = 9'b1_1111_1100;
    localparam logic [8:0] V_LU    = 9'b0_0111_0100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_memread, ex_redirect, mem_req, mem_ack;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_err;

    int tests_run    = 0;
    int tests_failed = 0;

    pipe_hazard_ctrl #(
        .BOOT_CYCLES (BOOT),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .memwb_flush (memwb_flush),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    logic [8:0] obs;
    assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush};

    // Reference model: cycles since reset release, outstanding-access flag, its age, error flag.
    int m_since    = 0;
    bit m_waiting  = 1'b0;
    int m_wait_len = 0;
    bit m_err      = 1'b0;

    function automatic bit m_booting();
        return m_since < BOOT;
    endfunction

    function automatic bit m_frozen();
        return !m_booting() && !mem_ack && (m_waiting || mem_req);
    endfunction

    function automatic bit m_load_use();
        return ex_memread && (ex_rd != 5'd0) &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    endfunction

    function automatic logic [8:0] m_expect();
        if (m_booting())  return V_BOOT;
        if (m_frozen())   return V_FRZ;
        if (ex_redirect)  return V_REDIR;
        if (m_load_use()) return V_LU;
        return V_RUN;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_since    <= 0;
            m_waiting  <= 1'b0;
            m_wait_len <= 0;
            m_err      <= 1'b0;
        end else begin
            if (m_since < 1000) m_since <= m_since + 1;
            if (m_booting()) begin
                m_waiting  <= 1'b0;
                m_wait_len <= 0;
            end else if (m_frozen()) begin
                if (m_waiting && m_wait_len == TO) m_err <= 1'b1;
                m_waiting  <= 1'b1;
                m_wait_len <= m_waiting ? m_wait_len + 1 : 1;
            end else begin
                m_waiting  <= 1'b0;
                m_wait_len <= 0;
            end
        end
    end

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_memread = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (obs !== V_BOOT) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected %b", obs, V_BOOT);
        end
        tests_run++;
        if (mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mem_err: got %b expected 0", mem_err);
        end
        reset = 1'b0;
        for (int i = 0; i < BOOT + 2; i++) begin
            #1;
            tests_run++;
            if (obs !== ((i < BOOT) ? V_BOOT : V_RUN)) begin
                tests_failed++;
                $display("FAIL boot_seq[%0d]: got %b expected %b", i, obs, (i < BOOT) ? V_BOOT : V_RUN);
            end
            tick();
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
        #1;
        tests_run++;
        if (obs !== V_LU) begin
            tests_failed++;
            $display("FAIL load_use_stall: got %b expected %b", obs, V_LU);
        end
        tick();
        ex_memread = 1'b0;
        #1;
        tests_run++;
        if (obs !== V_RUN) begin
            tests_failed++;
            $display("FAIL load_use_release: got %b expected %b", obs, V_RUN);
        end
        tick();
        $display("[TB] test_load_use done");
    endtask

    task automatic test_no_stall();
        clear_inputs();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1'b1;
        #1;
        tests_run++;
        if (obs !== V_RUN) begin
            tests_failed++;
            $display("FAIL no_stall_rd0: got %b expected %b", obs, V_RUN);
        end
        tick();
        ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b0;
        #1;
        tests_run++;
        if (obs !== V_RUN) begin
            tests_failed++;
            $display("FAIL no_stall_unused: got %b expected %b", obs, V_RUN);
        end
        tick();
        $display("[TB] test_no_stall done");
    endtask

    task automatic test_redirect();
        clear_inputs();
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1; ex_redirect = 1'b1;
        #1;
        tests_run++;
        if (obs !== V_REDIR) begin
            tests_failed++;
            $display("FAIL redirect_over_load_use: got %b expected %b", obs, V_REDIR);
        end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (obs !== V_RUN) begin
            tests_failed++;
            $display("FAIL redirect_release: got %b expected %b", obs, V_RUN);
        end
        tick();
        $display("[TB] test_redirect done");
    endtask

    task automatic test_mem_wait();
        clear_inputs();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (obs !== V_FRZ) begin
                tests_failed++;
                $display("FAIL mem_wait_frozen[%0d]: got %b expected %b", i, obs, V_FRZ);
            end
            tick();
        end
        mem_ack = 1'b1;
        #1;
        tests_run++;
        if (obs !== V_RUN) begin
            tests_failed++;
            $display("FAIL mem_wait_ack: got %b expected %b", obs, V_RUN);
        end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (obs !== V_RUN) begin
            tests_failed++;
            $display("FAIL mem_wait_back_to_run: got %b expected %b", obs, V_RUN);
        end
        tick();
        $display("[TB] test_mem_wait done");
    endtask

    task automatic test_wait_redirect();
        clear_inputs();
        mem_req = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (obs !== V_FRZ) begin
                tests_failed++;
                $display("FAIL wait_redirect_frozen[%0d]: got %b expected %b", i, obs, V_FRZ);
            end
            tick();
        end
        mem_ack = 1'b1;
        #1;
        tests_run++;
        if (obs !== V_REDIR) begin
            tests_failed++;
            $display("FAIL wait_redirect_ack: got %b expected %b", obs, V_REDIR);
        end
        tick();
        clear_inputs();
        tick();
        $display("[TB] test_wait_redirect done");
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = tests_failed;
        for (int i = 0; i < 600; i++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom % 2);
            id_rs2_used = 1'($urandom % 2);
            ex_memread  = 1'(($urandom % 3) == 0);
            ex_redirect = 1'(($urandom % 6) == 0);
            mem_req     = 1'(($urandom % 4) == 0);
            mem_ack     = (i < 400) ? 1'(($urandom % 3) != 0) : 1'(($urandom % 6) == 0);
            #1;
            tests_run++;
            if (obs !== m_expect()) begin
                tests_failed++;
                $display("FAIL rand_outputs cycle %0d: got %b expected %b", i, obs, m_expect());
            end
            tests_run++;
            if (mem_err !== m_err) begin
                tests_failed++;
                $display("FAIL rand_mem_err cycle %0d: got %b expected %b", i, mem_err, m_err);
            end
            tick();
        end
        clear_inputs();
        $display("[TB] test_random done, %0d new failures", tests_failed - errs_before);
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        mem_req = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (obs !== V_BOOT) begin
            tests_failed++;
            $display("FAIL mid_wait_reset_outputs: got %b expected %b", obs, V_BOOT);
        end
        tests_run++;
        if (mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_wait_reset_err: got %b expected 0", mem_err);
        end
        tick();
        reset = 1'b0;
        clear_inputs();
        for (int i = 0; i < BOOT + 1; i++) begin
            #1;
            tests_run++;
            if (pc_en !== ((i < BOOT) ? 1'b0 : 1'b1)) begin
                tests_failed++;
                $display("FAIL mid_wait_pc_en[%0d]: got %b expected %b", i, pc_en, (i < BOOT) ? 1'b0 : 1'b1);
            end
            tick();
        end
        $display("[TB] test_reset_mid_wait done");
    endtask

    task automatic test_timeout();
        clear_inputs();
        mem_req = 1'b1;
        for (int k = 0; k <= TO; k++) begin
            #1;
            tests_run++;
            if (mem_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_early[%0d]: got %b expected 0", k, mem_err);
            end
            tick();
        end
        #1;
        tests_run++;
        if (mem_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_set: got %b expected 1", mem_err);
        end
        tests_run++;
        if (obs !== V_FRZ) begin
            tests_failed++;
            $display("FAIL timeout_still_waiting: got %b expected %b", obs, V_FRZ);
        end
        mem_ack = 1'b1;
        tick();
        clear_inputs();
        tick();
        #1;
        tests_run++;
        if (mem_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_sticky: got %b expected 1", mem_err);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_cleared_by_reset: got %b expected 0", mem_err);
        end
        tick();
        reset = 1'b0;
        repeat (BOOT + 1) tick();
        $display("[TB] test_timeout done");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_stall();
        test_redirect();
        test_mem_wait();
        test_wait_redirect();
        test_random();
        test_reset_mid_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
